// File: rtl/sc_pkg.sv
// ---------------------------------------------------------------------------
// sc_pkg
// Shared constants, types and helpers for the stochastic-computing slice.
//   WIDTH     : width of the RNG state and the binary operand
//   SEED      : reset value of the RNG state, also the lock-up escape value
//   ROT       : left-rotate amount for the second, decorrelated random number
//   LFSR_TAPS : tap mask for x^8+x^6+x^5+x^4+1 (state bits 7,5,4,3)
//   sc_state_t: RNG state / operand type
//   lfsr_step : one Fibonacci LFSR step with zero-state escape
// ---------------------------------------------------------------------------
package sc_pkg;

   localparam int WIDTH = 8;
   localparam int ROT   = 3;

   typedef logic [WIDTH-1:0] sc_state_t;

   localparam sc_state_t SEED      = 8'h01;
   localparam sc_state_t LFSR_TAPS = 8'hB8;

   // The all-zero state is a fixed point of an XOR-feedback LFSR. It is
   // reloaded with the seed so that the generator cannot lock up if it is
   // ever presented with zero.
   function automatic sc_state_t lfsr_step(input sc_state_t state,
                                           input sc_state_t seed);
      sc_state_t nxt;
      if (state == '0) begin
         nxt = seed;
      end else begin
         nxt = {state[WIDTH-2:0], ^(state & LFSR_TAPS)};
      end
      return nxt;
   endfunction

endpackage

// File: rtl/sc_sng.sv
// ---------------------------------------------------------------------------
// sc_sng
// Comparator-based stochastic number generator. Produces a 1 with
// probability operand/2^W when rand_val is uniformly distributed.
//   rand_val : input  [W-1:0] random number
//   operand  : input  [W-1:0] binary operand (unsigned)
//   sc_bit   : output         stochastic bit, rand_val < operand
// ---------------------------------------------------------------------------
module sc_sng #(
   parameter int W = 8
) (
   input  logic [W-1:0] rand_val,
   input  logic [W-1:0] operand,
   output logic         sc_bit
);

   assign sc_bit = (rand_val < operand);

endmodule

// File: rtl/circuit.sv
// ---------------------------------------------------------------------------
// circuit
// Stochastic-computing datapath slice. Each cycle it advances an externally
// looped LFSR state, turns input_b into two stochastic bits using two
// decorrelated random numbers, and registers majority(x_a, x_b, in_x_1).
// The first stochastic bit is also registered as the next delay bit.
//   clk            : input          rising-edge clock
//   rst_n          : input          asynchronous reset, active HIGH
//   input_s        : input  [W-1:0] current RNG state (normally output_s)
//   input_b        : input  [W-1:0] binary operand, p = input_b/2^W
//   in_x_1         : input          delayed SC bit (normally out_x_1)
//   output_s       : output [W-1:0] next RNG state, registered
//   output_circuit : output         SC result bit, registered
//   out_x_1        : output         delay bit for the next cycle, registered
// ---------------------------------------------------------------------------
module circuit
   import sc_pkg::*;
#(
   parameter int        WIDTH = sc_pkg::WIDTH,
   parameter sc_state_t SEED  = sc_pkg::SEED,
   parameter int        ROT   = sc_pkg::ROT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] input_s,
   input  logic [WIDTH-1:0] input_b,
   input  logic             in_x_1,
   output logic [WIDTH-1:0] output_s,
   output logic             output_circuit,
   output logic             out_x_1
);

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] nxt_s;
   logic             x_a;
   logic             x_b;
   logic             maj;

   // Two random numbers from one state: the rotated copy moves the high
   // bits low so the two comparisons are far less correlated than they
   // would be with the raw state used twice.
   assign r_a = input_s;
   assign r_b = (input_s << ROT) | (input_s >> (WIDTH - ROT));

   sc_sng #(.W(WIDTH)) u_sng_a (
      .rand_val (r_a),
      .operand  (input_b),
      .sc_bit   (x_a)
   );

   sc_sng #(.W(WIDTH)) u_sng_b (
      .rand_val (r_b),
      .operand  (input_b),
      .sc_bit   (x_b)
   );

   assign nxt_s = lfsr_step(input_s, SEED);

   // Three-input majority is the sequential SC function; with the delay
   // bit holding last cycle's x_a its expected value is 3p^2 - 2p^3.
   assign maj = (x_a & x_b) | (x_a & in_x_1) | (x_b & in_x_1);

   // All state of the block lives here. Reset is asynchronous and
   // active-high, so the seed and zeroed outputs appear immediately.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         output_s       <= SEED;
         output_circuit <= 1'b0;
         out_x_1        <= 1'b0;
      end else begin
         output_s       <= nxt_s;
         output_circuit <= maj;
         out_x_1        <= x_a;
      end
   end

endmodule

// File: tb/tb_circuit.sv
// ---------------------------------------------------------------------------
// tb_circuit
// Self-checking bench for circuit. Expected values come from a behavioural
// model built on integer arithmetic (parity via $countones, rotation via
// shifts on ints, majority via a sum of bits).
// ---------------------------------------------------------------------------
module tb_circuit;

   logic       clk;
   logic       rst_n;
   logic [7:0] input_s;
   logic [7:0] input_b;
   logic       in_x_1;
   logic [7:0] output_s;
   logic       output_circuit;
   logic       out_x_1;

   int num_checks = 0;
   int num_passed = 0;

   circuit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .input_s        (input_s),
      .input_b        (input_b),
      .in_x_1         (in_x_1),
      .output_s       (output_s),
      .output_circuit (output_circuit),
      .out_x_1        (out_x_1)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Next LFSR state: multiply by two and add the parity of taps 7,5,4,3.
   function automatic int model_next(input int s);
      int fb;
      if (s == 0) return 1;
      fb = $countones(s & 'hB8) % 2;
      return (s * 2 + fb) % 256;
   endfunction

   function automatic int model_rot(input int s);
      return ((s << 3) | (s >> 5)) & 255;
   endfunction

   function automatic int model_maj(input int a, input int b, input int c);
      return ((a + b + c) >= 2) ? 1 : 0;
   endfunction

   task automatic checkOutput(input string tag, input int actual, input int expected);
      num_checks++;
      if (actual == expected) begin
         num_passed++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   // Drive one set of inputs, let one rising edge pass, then check all
   // three registered outputs against the model.
   task automatic applyStimulus(input string tag, input int s, input int b, input int x);
      int xa, xb;
      input_s = 8'(s);
      input_b = 8'(b);
      in_x_1  = x[0];
      xa = (s < b) ? 1 : 0;
      xb = (model_rot(s) < b) ? 1 : 0;
      @(posedge clk);
      #1;
      checkOutput({tag, "_s"},   int'(output_s),       model_next(s));
      checkOutput({tag, "_out"}, int'(output_circuit), model_maj(xa, xb, x));
      checkOutput({tag, "_x1"},  int'(out_x_1),        xa);
   endtask

   // Pulse reset away from a clock edge and confirm the outputs change
   // without waiting for a clock.
   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rst_s",   int'(output_s),       1);
      checkOutput("rst_out", int'(output_circuit), 0);
      checkOutput("rst_x1",  int'(out_x_1),        0);
      #1;
      rst_n = 1'b0;
   endtask

   // 255 cycles with input_s and (optionally) in_x_1 looped back from the
   // DUT. The model tracks its own state and delay bit independently.
   task automatic runLoop(input int b, input bit force_x,
                          output int ones_out, output int ones_x,
                          output int zero_idx, output int ff_idx,
                          output int repeats, output int final_s);
      int  m_state, m_prev, xa, xb, xin, exp_s, exp_out;
      bit  seen [256];
      for (int k = 0; k < 256; k++) seen[k] = 1'b0;
      seen[1]  = 1'b1;
      m_state  = 1;
      m_prev   = 0;
      ones_out = 0;
      ones_x   = 0;
      zero_idx = -1;
      ff_idx   = -2;
      repeats  = 0;
      for (int i = 0; i < 255; i++) begin
         input_s = output_s;
         input_b = 8'(b);
         in_x_1  = force_x ? 1'b1 : out_x_1;
         xa      = (m_state < b) ? 1 : 0;
         xb      = (model_rot(m_state) < b) ? 1 : 0;
         xin     = force_x ? 1 : m_prev;
         exp_out = model_maj(xa, xb, xin);
         exp_s   = model_next(m_state);
         if (m_state == 255) ff_idx = i;
         @(posedge clk);
         #1;
         checkOutput("loop_s",   int'(output_s),       exp_s);
         checkOutput("loop_out", int'(output_circuit), exp_out);
         checkOutput("loop_x1",  int'(out_x_1),        xa);
         if (output_circuit) ones_out++;
         else zero_idx = i;
         if (out_x_1) ones_x++;
         if (i < 254) begin
            if (seen[output_s]) repeats++;
            seen[output_s] = 1'b1;
         end
         m_state = exp_s;
         m_prev  = xa;
      end
      final_s = int'(output_s);
   endtask

   initial begin
      int ones_out, ones_x, zero_idx, ff_idx, repeats, final_s;
      int rs, rb;

      rst_n   = 1'b0;
      input_s = 8'($urandom);
      input_b = 8'($urandom);
      in_x_1  = 1'($urandom);
      #1;
      rst_n = 1'b1;
      #1;
      checkOutput("init_rst_s",   int'(output_s),       1);
      checkOutput("init_rst_out", int'(output_circuit), 0);
      checkOutput("init_rst_x1",  int'(out_x_1),        0);
      @(negedge clk);
      rst_n = 1'b0;

      $display("[TB] directed LFSR steps");
      applyStimulus("step01", 'h01, 0, 0);
      applyStimulus("step80", 'h80, 0, 0);
      applyStimulus("step00", 'h00, 0, 0);

      $display("[TB] delay bit");
      applyStimulus("delay1", 'h10, 128, 1);
      applyStimulus("delay0", 'h10, 128, 0);

      $display("[TB] full period, zero operand, in_x_1 forced high");
      doReset();
      runLoop(0, 1'b1, ones_out, ones_x, zero_idx, ff_idx, repeats, final_s);
      checkOutput("period_final",   final_s, 1);
      checkOutput("period_repeats", repeats, 0);
      checkOutput("zero_ones_out",  ones_out, 0);
      checkOutput("zero_ones_x1",   ones_x, 0);

      $display("[TB] full operand");
      doReset();
      runLoop(255, 1'b0, ones_out, ones_x, zero_idx, ff_idx, repeats, final_s);
      checkOutput("full_ones",     ones_out, 254);
      checkOutput("full_zero_pos", zero_idx, ff_idx);

      $display("[TB] mid-scale operand");
      doReset();
      runLoop(128, 1'b0, ones_out, ones_x, zero_idx, ff_idx, repeats, final_s);
      checkOutput("mid_ones_x1", ones_x, 127);
      checkOutput("mid_ones_out_in_range",
                  ((ones_out >= 112) && (ones_out <= 142)) ? 1 : 0, 1);

      $display("[TB] randomized open-loop stimulus with occasional resets");
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(39) == 0) begin
            doReset();
         end
         case ($urandom_range(15))
            0:       rs = 0;
            1:       rs = 255;
            default: rs = int'($urandom_range(255));
         endcase
         case ($urandom_range(15))
            0:       rb = 0;
            1:       rb = 255;
            default: rb = int'($urandom_range(255));
         endcase
         applyStimulus("rand", rs, rb, int'($urandom_range(1)));
      end

      $display("[TB] %0d/%0d checks passed", num_passed, num_checks);
      $finish;
   end

endmodule

// File: doc/circuit.md
Name: circuit

Overview:
- Stochastic-computing (SC) datapath slice with one clock domain.
- Each cycle it advances an externally looped 8-bit LFSR state, converts the binary operand `input_b` into stochastic bits by comparison, and evaluates a sequential SC function using one externally looped delay bit.
- Output is the stochastic bitstream `output_circuit`. An upstream or bench counter integrates it to recover the probability.

Parameters:
- WIDTH, 8: width of the RNG state and the binary operand.
- SEED, 8'h01: reset value of `output_s`; also the recovery value when the state is zero.
- ROT, 3: left-rotate amount used to derive the second, decorrelated random number.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset. Asynchronous, active-high: rst_n=1 resets; normal operation while rst_n=0.
- input_s  input  WIDTH  current RNG state. Normally `output_s` fed back externally.
- input_b  input  WIDTH  binary operand, unsigned. Probability p = input_b/256.
- in_x_1  input  1  delayed SC bit. Normally `out_x_1` fed back externally.
- output_s  output  WIDTH  next RNG state, registered.
- output_circuit  output  1  SC result bit, registered.
- out_x_1  output  1  delay-state bit for the next cycle, registered.

Behaviour:
- Reset (async, while rst_n=1): output_s=SEED, output_circuit=0, out_x_1=0.
- LFSR next state, Fibonacci, polynomial x^8+x^6+x^5+x^4+1, maximal period 255:
  - nxt = {input_s[6:0], input_s[7]^input_s[5]^input_s[4]^input_s[3]}
  - if input_s==0, nxt=SEED (lock-up escape).
  - output_s <= nxt on each rising edge.
- Stochastic number generators (combinational, from the current input_s):
  - r_a = input_s
  - r_b = input_s rotated left by ROT
  - x_a = (r_a < input_b), unsigned compare
  - x_b = (r_b < input_b), unsigned compare
- Function, registered with latency 1 cycle:
  - output_circuit <= majority(x_a, x_b, in_x_1)
  - out_x_1 <= x_a
- Expected value with independent inputs: 3p^2 - 2p^3.
- Boundary conditions:
  - input_b=0: x_a=x_b=0, so output_circuit=0 one cycle later regardless of in_x_1.
  - input_b=255: x_a=x_b=1 except when input_s=255.
- input_b may change on any cycle. There is no handshake; the new value takes effect at the next edge.
- Asserting reset mid-stream immediately forces the reset values. Operation resumes from SEED on the first edge after reset deasserts.
- All state is held only in `output_s`, `output_circuit` and `out_x_1`. The block has no hidden counters.

Decomposition:
- Package `sc_pkg`: WIDTH, SEED, ROT, LFSR tap constants, and a state typedef of WIDTH bits.
- One natural sub-module, `sc_sng`: a comparator-based stochastic number generator (rand vs. operand giving one bit), instantiated twice.
- The LFSR step is a function in `sc_pkg`.

Test Plan:
- Reset: rst_n=1 with arbitrary inputs -> output_s=8'h01, output_circuit=0, out_x_1=0 immediately, without waiting for a clock.
- LFSR step, rst_n=0, one edge per check:
  - input_s=8'h01 -> output_s=8'h02
  - input_s=8'h80 -> output_s=8'h01
  - input_s=8'h00 -> output_s=8'h01
  - Closed loop from 8'h01: returns to 8'h01 after exactly 255 edges with no repeat in between.
- Zero operand: input_b=0, in_x_1 forced to 1, closed-loop input_s -> output_circuit=0 and out_x_1=0 on every cycle after the first edge.
- Full operand: input_b=255, closed loop over one 255-cycle period -> exactly 254 ones on output_circuit; the single 0 appears the cycle after input_s=8'hFF.
- Mid-scale: input_b=128, closed loop for 255 cycles -> out_x_1 has exactly 127 ones; output_circuit ones count within 127±15.
- Delay bit: input_b=128, input_s=8'h10 (x_a=1, x_b=0). in_x_1=1 -> output_circuit=1; in_x_1=0 -> output_circuit=0, each one cycle later.
